memory_stage: RTL and testbench

- Pipeline stage that owns the EX/MEM register and the data-cache request for loads and stores.
- Consumes execute's results: ALUOut, dmemstore, dREN/dWEN, regWr/regSel/regDst, nPC, lui, halt, instr.
- Holds a load/store request toward the dcache until dhit, and stalls the pipeline meanwhile.
- Produces the MEM/WB register and the MEM-stage forwarding tap for the forwarding unit.

---
 rtl/memory_stage_pkg.sv | 25 ++
 rtl/memory_if.sv | 34 +++
 rtl/wb_mux.sv | 22 ++
 rtl/memory_stage.sv | 138 +++++++++++++
 tb/tb_memory_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: widths, writeback selector and request FSM states,
// plus the packed EX/MEM register layout.
package memory_stage_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {RS_ALU, RS_LOAD, RS_NPC, RS_LUI} regsel_t;
  typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_DONE, MS_HALTED} memstate_t;

  typedef struct packed {
    logic             ren;
    logic             wen;
    logic             regwr;
    logic [1:0]       regsel;
    logic [REG_W-1:0] regdst;
    word_t            aluout;
    word_t            store;
    word_t            npc;
    word_t            lui;
    logic             halt;
    word_t            instr;
  } exmem_t;
endpackage

// File: rtl/memory_if.sv
// Bundled view of the memory stage boundary, in the same style as the execute interface.
interface memory_if;
  import memory_stage_pkg::*;

  logic             memen, flush, wben;
  word_t            ALUOut, dmemstore_in, nPC, lui, instr;
  logic             dREN, dWEN, regWr, halt;
  logic [1:0]       regSel;
  logic [REG_W-1:0] regDst;
  logic             dhit;
  word_t            dmemload;
  logic             dmemREN, dmemWEN, mem_stall;
  word_t            dmemaddr, dmemstore;
  logic             fwd_wen;
  logic [REG_W-1:0] fwd_dst;
  word_t            fwd_dat;
  logic             regWr_next, halt_next;
  logic [REG_W-1:0] regDst_next;
  word_t            wdat_next, instr_next;

  modport mem (
    input  memen, flush, wben, ALUOut, dmemstore_in, dREN, dWEN, regWr, regSel, regDst,
           nPC, lui, halt, instr, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_wen, fwd_dst, fwd_dat,
           regWr_next, halt_next, regDst_next, wdat_next, instr_next
  );

  modport tb (
    output memen, flush, wben, ALUOut, dmemstore_in, dREN, dWEN, regWr, regSel, regDst,
           nPC, lui, halt, instr, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_wen, fwd_dst, fwd_dat,
           regWr_next, halt_next, regDst_next, wdat_next, instr_next
  );
endinterface

// File: rtl/wb_mux.sv
// Writeback source selector; also used by the writeback stage.
module wb_mux
  import memory_stage_pkg::*;
(
  input  logic [1:0] sel,
  input  word_t      alu,
  input  word_t      load,
  input  word_t      npc,
  input  word_t      lui,
  output word_t      dat
);
  always_comb begin
    dat = alu;
    case (sel)
      RS_ALU:  dat = alu;
      RS_LOAD: dat = load;
      RS_NPC:  dat = npc;
      RS_LUI:  dat = lui;
      default: dat = alu;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// EX/MEM register, dcache request FSM and MEM/WB register.
// Request valid/ready: dmemREN/dmemWEN are held with stable address/data until the cycle dhit=1.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        memen,
  input  logic        flush,
  input  logic        wben,
  input  logic [31:0] ALUOut,
  input  logic [31:0] dmemstore_in,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        regWr,
  input  logic [1:0]  regSel,
  input  logic [4:0]  regDst,
  input  logic [31:0] nPC,
  input  logic [31:0] lui,
  input  logic        halt,
  input  logic [31:0] instr,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        fwd_wen,
  output logic [4:0]  fwd_dst,
  output logic [31:0] fwd_dat,
  output logic        regWr_next,
  output logic        halt_next,
  output logic [4:0]  regDst_next,
  output logic [31:0] wdat_next,
  output logic [31:0] instr_next,
  output logic [1:0]  state
);
  exmem_t    ex, ex_in;
  memstate_t state_q;
  word_t     ldbuf, load_dat, sel_dat;
  logic      halted, mem_op, active, complete, wb_load, ex_load;

  always_comb begin
    ex_in        = '0;
    ex_in.ren    = dREN;
    ex_in.wen    = dWEN;
    ex_in.regwr  = regWr;
    ex_in.regsel = regSel;
    ex_in.regdst = regDst;
    ex_in.aluout = ALUOut;
    ex_in.store  = dmemstore_in;
    ex_in.npc    = nPC;
    ex_in.lui    = lui;
    ex_in.halt   = halt;
    ex_in.instr  = instr;
  end

  // A latched memory op issues its request combinationally from IDLE, so IDLE and BUSY both drive it.
  assign halted   = (state_q == MS_HALTED);
  assign mem_op   = ex.ren | ex.wen;
  assign active   = mem_op & ((state_q == MS_IDLE) | (state_q == MS_BUSY));
  assign complete = (active & dhit & wben) | ((state_q == MS_DONE) & wben);
  assign wb_load  = complete | (~mem_op & (state_q == MS_IDLE) & wben);

  // Stall covers a dhit seen while writeback is blocked, so EX/MEM keeps the op DONE still needs.
  assign mem_stall = (active & ~(dhit & wben)) | ((state_q == MS_DONE) & ~wben);
  assign ex_load   = memen & ~mem_stall & ~halted;

  // Both enables set is treated as a store.
  assign dmemREN   = active & ex.ren & ~ex.wen;
  assign dmemWEN   = active & ex.wen;
  assign dmemaddr  = active ? ex.aluout : '0;
  assign dmemstore = active ? ex.store : '0;

  assign load_dat = (state_q == MS_DONE) ? ldbuf : dmemload;

  wb_mux u_wb_mux (
    .sel  (ex.regsel),
    .alu  (ex.aluout),
    .load (load_dat),
    .npc  (ex.npc),
    .lui  (ex.lui),
    .dat  (sel_dat)
  );

  assign fwd_wen = ex.regwr & (ex.regdst != '0) & (ex.regsel != RS_LOAD);
  assign fwd_dst = ex.regdst;
  assign fwd_dat = sel_dat;
  assign state   = state_q;

  // A finished memory op that is not replaced becomes a bubble so it is neither reissued nor rewritten.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex <= '0;
    end else if (!halted) begin
      if (flush)         ex <= '0;
      else if (ex_load)  ex <= ex_in;
      else if (complete) ex <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= MS_IDLE;
      ldbuf   <= '0;
    end else begin
      if (active & dhit) ldbuf <= dmemload;
      case (state_q)
        MS_IDLE, MS_BUSY: begin
          if (flush)       state_q <= MS_IDLE;
          else if (active) state_q <= dhit ? (wben ? MS_IDLE : MS_DONE) : MS_BUSY;
          else             state_q <= MS_IDLE;
        end
        MS_DONE:   if (flush | wben) state_q <= MS_IDLE;
        MS_HALTED: state_q <= MS_HALTED;
        default:   state_q <= MS_IDLE;
      endcase
      if (wb_load & ex.halt) state_q <= MS_HALTED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regWr_next  <= 1'b0;
      halt_next   <= 1'b0;
      regDst_next <= '0;
      wdat_next   <= '0;
      instr_next  <= '0;
    end else if (wb_load) begin
      regWr_next  <= ex.regwr & (ex.regdst != '0);
      halt_next   <= ex.halt;
      regDst_next <= ex.regdst;
      wdat_next   <= sel_dat;
      instr_next  <= ex.instr;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU/load/store paths, DONE wait, flush, reset, halt, streaming.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        memen = 1'b0, flush = 1'b0, wben = 1'b0;
  logic [31:0] ALUOut = '0, dmemstore_in = '0, nPC = '0, lui = '0, instr = '0;
  logic        dREN = 1'b0, dWEN = 1'b0, regWr = 1'b0, halt = 1'b0;
  logic [1:0]  regSel = '0;
  logic [4:0]  regDst = '0;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = '0;
  logic        dmemREN, dmemWEN, mem_stall, fwd_wen, regWr_next, halt_next;
  logic [31:0] dmemaddr, dmemstore, fwd_dat, wdat_next, instr_next;
  logic [4:0]  fwd_dst, regDst_next;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK(CLK), .nRST(nRST), .memen(memen), .flush(flush), .wben(wben),
    .ALUOut(ALUOut), .dmemstore_in(dmemstore_in), .dREN(dREN), .dWEN(dWEN),
    .regWr(regWr), .regSel(regSel), .regDst(regDst), .nPC(nPC), .lui(lui),
    .halt(halt), .instr(instr), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .fwd_wen(fwd_wen), .fwd_dst(fwd_dst), .fwd_dat(fwd_dat),
    .regWr_next(regWr_next), .halt_next(halt_next), .regDst_next(regDst_next),
    .wdat_next(wdat_next), .instr_next(instr_next), .state(state)
  );

  always @(posedge CLK) assert (!(dREN && dWEN)) else $error("FAIL illegal_ren_wen: both set");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_op(input logic ren, input logic wen, input logic rw, input logic [1:0] sel,
                          input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] st,
                          input logic [31:0] npc_v, input logic [31:0] lui_v, input logic hlt,
                          input logic [31:0] ins);
    dREN = ren; dWEN = wen; regWr = rw; regSel = sel; regDst = dst; ALUOut = alu;
    dmemstore_in = st; nPC = npc_v; lui = lui_v; halt = hlt; instr = ins; memen = 1'b1;
  endtask

  task automatic idle_in();
    memen = 1'b0; dREN = 1'b0; dWEN = 1'b0; regWr = 1'b0; regSel = '0; regDst = '0;
    ALUOut = '0; dmemstore_in = '0; nPC = '0; lui = '0; halt = 1'b0; instr = '0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin n_err++; $display("FAIL reset_req: got %b want 000", {dmemREN, dmemWEN, mem_stall}); end
    n_cmp++; if ({regWr_next, halt_next, fwd_wen} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {regWr_next, halt_next, fwd_wen}); end
    n_cmp++; if (wdat_next !== 32'h0) begin n_err++; $display("FAIL reset_wdat: got %h want 0", wdat_next); end
    n_cmp++; if (state !== MS_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    @(negedge CLK); nRST = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    wben = 1'b1;
    drive_op(0, 0, 1, RS_ALU, 5'd8, 32'h10, 0, 0, 0, 0, 32'h01084020);
    tick(); idle_in(); #1;
    n_cmp++; if ({fwd_wen, fwd_dst} !== {1'b1, 5'd8}) begin n_err++; $display("FAIL alu_fwd: got %b/%0d want 1/8", fwd_wen, fwd_dst); end
    n_cmp++; if (fwd_dat !== 32'h10) begin n_err++; $display("FAIL alu_fwd_dat: got %h want 10", fwd_dat); end
    n_cmp++; if ({mem_stall, dmemREN, dmemWEN} !== 3'b000) begin n_err++; $display("FAIL alu_nostall: got %b want 000", {mem_stall, dmemREN, dmemWEN}); end
    tick();
    n_cmp++; if (wdat_next !== 32'h10) begin n_err++; $display("FAIL alu_wdat: got %h want 10", wdat_next); end
    n_cmp++; if ({regWr_next, regDst_next} !== {1'b1, 5'd8}) begin n_err++; $display("FAIL alu_wb: got %b/%0d want 1/8", regWr_next, regDst_next); end
    n_cmp++; if (instr_next !== 32'h01084020) begin n_err++; $display("FAIL alu_instr: got %h want 01084020", instr_next); end
  endtask

  task automatic test_load();
    wben = 1'b1;
    drive_op(1, 0, 1, RS_LOAD, 5'd9, 32'h100, 0, 0, 0, 0, 32'h8c090100);
    tick(); idle_in(); dhit = 1'b0;
    n_cmp++; if (fwd_wen !== 1'b0) begin n_err++; $display("FAIL load_nofwd: got %b want 0", fwd_wen); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b101) begin n_err++; $display("FAIL load_wait%0d: got %b want 101", i, {dmemREN, dmemWEN, mem_stall}); end
      n_cmp++; if (dmemaddr !== 32'h100) begin n_err++; $display("FAIL load_addr%0d: got %h want 100", i, dmemaddr); end
      tick();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF; #1;
    n_cmp++; if ({dmemREN, mem_stall} !== 2'b10) begin n_err++; $display("FAIL load_hit: got %b want 10", {dmemREN, mem_stall}); end
    tick(); dhit = 1'b0; dmemload = 32'h0;
    n_cmp++; if (wdat_next !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_wdat: got %h want deadbeef", wdat_next); end
    n_cmp++; if ({regWr_next, regDst_next} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL load_wb: got %b/%0d want 1/9", regWr_next, regDst_next); end
    #1;
    n_cmp++; if ({dmemREN, mem_stall, state} !== {2'b00, MS_IDLE}) begin n_err++; $display("FAIL load_after: got %b want 0000", {dmemREN, mem_stall, state}); end
  endtask

  task automatic test_store();
    wben = 1'b1;
    drive_op(0, 1, 0, RS_ALU, 5'd0, 32'h200, 32'hCAFE, 0, 0, 0, 32'hac0a0200);
    tick(); idle_in(); dhit = 1'b1; #1;
    n_cmp++; if ({dmemWEN, dmemREN, mem_stall} !== 3'b100) begin n_err++; $display("FAIL store_req: got %b want 100", {dmemWEN, dmemREN, mem_stall}); end
    n_cmp++; if (dmemstore !== 32'hCAFE) begin n_err++; $display("FAIL store_data: got %h want cafe", dmemstore); end
    n_cmp++; if (dmemaddr !== 32'h200) begin n_err++; $display("FAIL store_addr: got %h want 200", dmemaddr); end
    tick(); dhit = 1'b0;
    n_cmp++; if (regWr_next !== 1'b0) begin n_err++; $display("FAIL store_regwr: got %b want 0", regWr_next); end
    #1;
    n_cmp++; if ({dmemWEN, mem_stall} !== 2'b00) begin n_err++; $display("FAIL store_once: got %b want 00", {dmemWEN, mem_stall}); end
  endtask

  task automatic test_done();
    wben = 1'b1;
    drive_op(1, 0, 1, RS_LOAD, 5'd10, 32'h300, 0, 0, 0, 0, 32'h8c0a0300);
    tick(); idle_in(); wben = 1'b0; dhit = 1'b1; dmemload = 32'h12345678; #1;
    n_cmp++; if (dmemREN !== 1'b1) begin n_err++; $display("FAIL done_req: got %b want 1", dmemREN); end
    tick(); dhit = 1'b0; dmemload = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (state !== MS_DONE) begin n_err++; $display("FAIL done_state%0d: got %0d want 2", i, state); end
      n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b001) begin n_err++; $display("FAIL done_hold%0d: got %b want 001", i, {dmemREN, dmemWEN, mem_stall}); end
      n_cmp++; if (wdat_next !== 32'h0) begin n_err++; $display("FAIL done_wb_held%0d: got %h want 0", i, wdat_next); end
      tick();
    end
    wben = 1'b1; #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL done_release: got %b want 0", mem_stall); end
    tick();
    n_cmp++; if (wdat_next !== 32'h12345678) begin n_err++; $display("FAIL done_wdat: got %h want 12345678", wdat_next); end
    n_cmp++; if ({regWr_next, regDst_next} !== {1'b1, 5'd10}) begin n_err++; $display("FAIL done_wb: got %b/%0d want 1/10", regWr_next, regDst_next); end
    #1;
    n_cmp++; if ({dmemREN, state} !== {1'b0, MS_IDLE}) begin n_err++; $display("FAIL done_noreissue: got %b want 000", {dmemREN, state}); end
  endtask

  task automatic test_flush();
    wben = 1'b1;
    drive_op(0, 0, 1, RS_ALU, 5'd5, 32'h99, 0, 0, 0, 0, 32'h1);
    tick();
    drive_op(1, 0, 1, RS_LOAD, 5'd11, 32'h400, 0, 0, 0, 0, 32'h2);
    tick(); idle_in(); dhit = 1'b0; #1;
    n_cmp++; if ({dmemREN, wdat_next} !== {1'b1, 32'h99}) begin n_err++; $display("FAIL flush_pre: got %b/%h want 1/99", dmemREN, wdat_next); end
    tick();
    n_cmp++; if (state !== MS_BUSY) begin n_err++; $display("FAIL flush_busy: got %0d want 1", state); end
    flush = 1'b1;
    tick(); flush = 1'b0; #1;
    n_cmp++; if ({dmemREN, mem_stall, state} !== {2'b00, MS_IDLE}) begin n_err++; $display("FAIL flush_drop: got %b want 0000", {dmemREN, mem_stall, state}); end
    tick();
    n_cmp++; if ({regWr_next, halt_next, regDst_next, wdat_next} !== 39'h0) begin n_err++; $display("FAIL flush_bubble: got %b/%0d/%h want 0/0/0", regWr_next, regDst_next, wdat_next); end
  endtask

  task automatic test_reset_mid();
    wben = 1'b1;
    drive_op(0, 0, 1, RS_ALU, 5'd12, 32'h55, 0, 0, 0, 0, 32'h3);
    tick();
    drive_op(1, 0, 1, RS_LOAD, 5'd13, 32'h500, 0, 0, 0, 0, 32'h4);
    tick(); idle_in(); dhit = 1'b0; #1;
    n_cmp++; if ({dmemREN, wdat_next} !== {1'b1, 32'h55}) begin n_err++; $display("FAIL rstmid_pre: got %b/%h want 1/55", dmemREN, wdat_next); end
    #1; nRST = 1'b0; #1;
    n_cmp++; if ({dmemREN, mem_stall, state} !== {2'b00, MS_IDLE}) begin n_err++; $display("FAIL rstmid_drop: got %b want 0000", {dmemREN, mem_stall, state}); end
    n_cmp++; if ({regWr_next, regDst_next, wdat_next} !== 38'h0) begin n_err++; $display("FAIL rstmid_wb: got %b/%0d/%h want 0/0/0", regWr_next, regDst_next, wdat_next); end
    @(negedge CLK); nRST = 1'b1;
    tick();
    n_cmp++; if (dmemREN !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got %b want 0", dmemREN); end
  endtask

  task automatic test_halt();
    wben = 1'b1;
    drive_op(0, 0, 0, RS_ALU, 5'd0, 32'h0, 0, 0, 0, 1, 32'hFC000000);
    tick(); idle_in();
    tick();
    n_cmp++; if ({halt_next, state} !== {1'b1, MS_HALTED}) begin n_err++; $display("FAIL halt_enter: got %b want 111", {halt_next, state}); end
    drive_op(0, 0, 1, RS_ALU, 5'd13, 32'h77, 0, 0, 0, 0, 32'h5);
    tick(); tick();
    n_cmp++; if ({halt_next, regWr_next, wdat_next} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL halt_frozen: got %b/%b/%h want 1/0/0", halt_next, regWr_next, wdat_next); end
    n_cmp++; if (instr_next !== 32'hFC000000) begin n_err++; $display("FAIL halt_instr: got %h want fc000000", instr_next); end
    drive_op(1, 0, 1, RS_LOAD, 5'd14, 32'h600, 0, 0, 0, 0, 32'h6);
    tick(); #1;
    n_cmp++; if ({dmemREN, mem_stall} !== 2'b00) begin n_err++; $display("FAIL halt_noreq: got %b want 00", {dmemREN, mem_stall}); end
    idle_in(); nRST = 1'b0; #2;
    n_cmp++; if ({halt_next, state} !== {1'b0, MS_IDLE}) begin n_err++; $display("FAIL halt_reset: got %b want 000", {halt_next, state}); end
    @(negedge CLK); nRST = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    wben = 1'b1;
    drive_op(0, 0, 1, RS_ALU, 5'd1, 32'h11, 0, 0, 0, 0, 32'h7);
    tick();
    n_cmp++; if (fwd_dat !== 32'h11) begin n_err++; $display("FAIL b2b_fwd_alu: got %h want 11", fwd_dat); end
    drive_op(0, 0, 1, RS_NPC, 5'd31, 32'h999, 0, 32'h44, 0, 0, 32'h8);
    tick();
    n_cmp++; if ({wdat_next, regDst_next} !== {32'h11, 5'd1}) begin n_err++; $display("FAIL b2b_wb_alu: got %h/%0d want 11/1", wdat_next, regDst_next); end
    n_cmp++; if (fwd_dat !== 32'h44) begin n_err++; $display("FAIL b2b_fwd_npc: got %h want 44", fwd_dat); end
    drive_op(0, 0, 1, RS_LUI, 5'd2, 32'h999, 0, 32'h44, 32'hABCD0000, 0, 32'h9);
    tick();
    n_cmp++; if ({wdat_next, regDst_next} !== {32'h44, 5'd31}) begin n_err++; $display("FAIL b2b_wb_npc: got %h/%0d want 44/31", wdat_next, regDst_next); end
    n_cmp++; if (fwd_dat !== 32'hABCD0000) begin n_err++; $display("FAIL b2b_fwd_lui: got %h want abcd0000", fwd_dat); end
    drive_op(0, 0, 1, RS_ALU, 5'd0, 32'h5, 0, 0, 0, 0, 32'hA);
    tick();
    n_cmp++; if (wdat_next !== 32'hABCD0000) begin n_err++; $display("FAIL b2b_wb_lui: got %h want abcd0000", wdat_next); end
    n_cmp++; if (fwd_wen !== 1'b0) begin n_err++; $display("FAIL b2b_fwd_r0: got %b want 0", fwd_wen); end
    idle_in();
    tick();
    n_cmp++; if ({regWr_next, wdat_next} !== {1'b0, 32'h5}) begin n_err++; $display("FAIL b2b_wb_r0: got %b/%h want 0/5", regWr_next, wdat_next); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_done();
    test_flush();
    test_reset_mid();
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
